// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the controller state encoding, forward-select codes and the operand compare helper.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    ERR      = 2'd3
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // The younger producer (MEM) wins over WB; $0 is never forwarded.
  function automatic logic [1:0] fwd_select(input logic [4:0] src,
                                            input logic       mem_we,
                                            input logic [4:0] mem_wa,
                                            input logic       wb_we,
                                            input logic [4:0] wb_wa);
    logic [1:0] sel;
    sel = FWD_RF;
    if (mem_we && (mem_wa != REG_ZERO) && (mem_wa == src))
      sel = FWD_MEM;
    else if (wb_we && (wb_wa != REG_ZERO) && (wb_wa == src))
      sel = FWD_WB;
    return sel;
  endfunction

endpackage

// File: rtl/pipe_fwd_unit.sv
// EX-stage forwarding compare: one slice per ALU operand (rs -> A, rt -> B).
// Purely combinational; active in every controller state.
module pipe_fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] ex_rs_i,
  input  logic [4:0] ex_rt_i,
  input  logic       mem_reg_write_i,
  input  logic [4:0] mem_w_addr_i,
  input  logic       wb_reg_write_i,
  input  logic [4:0] wb_w_addr_i,
  output logic [1:0] fwd_a_o,
  output logic [1:0] fwd_b_o
);

  assign fwd_a_o = fwd_select(ex_rs_i, mem_reg_write_i, mem_w_addr_i,
                              wb_reg_write_i, wb_w_addr_i);
  assign fwd_b_o = fwd_select(ex_rt_i, mem_reg_write_i, mem_w_addr_i,
                              wb_reg_write_i, wb_w_addr_i);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Sequencing controller for the 5-stage pipeline: stalls, flushes, DM wait and forwarding.
// Optional PIPE_HAZARD_PERF_EN adds saturating stall/flush/memwait counters.
//
// state    | meaning
// INIT     | post-reset flush window, RST_FLUSH_CYC cycles, DM ignored
// RUN      | normal issue; DM stall, branch flush, load-use bubble
// MEM_WAIT | waiting for DM ready, watchdog counting
// ERR      | DM timeout, pipeline frozen until reset
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT   = 16,
  parameter int RST_FLUSH_CYC = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  id_rs_i,
  input  logic [4:0]  id_rt_i,
  input  logic        id_use_rs_i,
  input  logic        id_use_rt_i,
  input  logic [4:0]  ex_rs_i,
  input  logic [4:0]  ex_rt_i,
  input  logic        ex_reg_write_i,
  input  logic        ex_dm_read_i,
  input  logic [4:0]  ex_w_addr_i,
  input  logic        mem_reg_write_i,
  input  logic [4:0]  mem_w_addr_i,
  input  logic        wb_reg_write_i,
  input  logic [4:0]  wb_w_addr_i,
  input  logic        branch_taken_i,
  input  logic        dm_req_i,
  input  logic        dm_ready_i,
  output logic        pc_write_o,
  output logic        if_id_write_o,
  output logic        pipe_hold_o,
  output logic        id_ex_bubble_o,
  output logic        if_id_flush_o,
  output logic        id_ex_flush_o,
  output logic        ex_mem_flush_o,
  output logic        mem_wb_bubble_o,
  output logic [1:0]  fwd_a_o,
  output logic [1:0]  fwd_b_o,
  output logic        err_o
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o,
  output logic [31:0] memwait_cnt_o
`endif
);

  localparam logic [7:0] TIMEOUT_C   = 8'(MEM_TIMEOUT);
  localparam logic [7:0] INIT_LAST_C = 8'(RST_FLUSH_CYC - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       mem_stall;
  logic       load_use;

  assign mem_stall = dm_req_i && !dm_ready_i;
  assign load_use  = ex_dm_read_i && ex_reg_write_i && (ex_w_addr_i != REG_ZERO) &&
                     ((id_use_rs_i && (id_rs_i == ex_w_addr_i)) ||
                      (id_use_rt_i && (id_rt_i == ex_w_addr_i)));

  // One counter serves both the INIT window and the DM watchdog; it stays below 256.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= INIT;
      cnt   <= 8'd0;
    end else begin
      case (state)
        INIT: begin
          if (cnt == INIT_LAST_C) begin
            state <= RUN;
            cnt   <= 8'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RUN: begin
          if (mem_stall) begin
            state <= MEM_WAIT;
            cnt   <= 8'd1;
          end
        end
        MEM_WAIT: begin
          if (dm_ready_i) begin
            state <= RUN;
            cnt   <= 8'd0;
          end else if (cnt == TIMEOUT_C) begin
            state <= ERR;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ERR:     state <= ERR;
        default: state <= INIT;
      endcase
    end
  end

  always_comb begin
    pc_write_o      = 1'b0;
    if_id_write_o   = 1'b0;
    pipe_hold_o     = 1'b0;
    id_ex_bubble_o  = 1'b0;
    if_id_flush_o   = 1'b0;
    id_ex_flush_o   = 1'b0;
    ex_mem_flush_o  = 1'b0;
    mem_wb_bubble_o = 1'b0;
    case (state)
      INIT: begin
        if_id_flush_o  = 1'b1;
        id_ex_flush_o  = 1'b1;
        ex_mem_flush_o = 1'b1;
      end
      RUN: begin
        if (mem_stall) begin
          pipe_hold_o     = 1'b1;
          mem_wb_bubble_o = 1'b1;
        end else if (branch_taken_i) begin
          pc_write_o     = 1'b1;
          if_id_write_o  = 1'b1;
          if_id_flush_o  = 1'b1;
          id_ex_flush_o  = 1'b1;
          ex_mem_flush_o = 1'b1;
        end else if (load_use) begin
          id_ex_bubble_o = 1'b1;
        end else begin
          pc_write_o    = 1'b1;
          if_id_write_o = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (dm_ready_i) begin
          pc_write_o    = 1'b1;
          if_id_write_o = 1'b1;
        end else begin
          pipe_hold_o     = 1'b1;
          mem_wb_bubble_o = 1'b1;
        end
      end
      default: pipe_hold_o = 1'b1;
    endcase
  end

  assign err_o = (state == ERR);

  pipe_fwd_unit u_fwd (
    .ex_rs_i         (ex_rs_i),
    .ex_rt_i         (ex_rt_i),
    .mem_reg_write_i (mem_reg_write_i),
    .mem_w_addr_i    (mem_w_addr_i),
    .wb_reg_write_i  (wb_reg_write_i),
    .wb_w_addr_i     (wb_w_addr_i),
    .fwd_a_o         (fwd_a_o),
    .fwd_b_o         (fwd_b_o)
  );

`ifdef PIPE_HAZARD_PERF_EN
  logic run_st;
  logic stall_ev;
  logic flush_ev;
  logic memwait_ev;

  assign run_st     = (state == RUN);
  assign stall_ev   = run_st && !mem_stall && !branch_taken_i && load_use;
  assign flush_ev   = run_st && !mem_stall && branch_taken_i;
  assign memwait_ev = (run_st && mem_stall) || (state == MEM_WAIT);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o   <= 32'd0;
      flush_cnt_o   <= 32'd0;
      memwait_cnt_o <= 32'd0;
    end else begin
      if (stall_ev && (stall_cnt_o != 32'hFFFF_FFFF))
        stall_cnt_o <= stall_cnt_o + 32'd1;
      if (flush_ev && (flush_cnt_o != 32'hFFFF_FFFF))
        flush_cnt_o <= flush_cnt_o + 32'd1;
      if (memwait_ev && (memwait_cnt_o != 32'hFFFF_FFFF))
        memwait_cnt_o <= memwait_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: stimulus queues expected output vectors,
// a negedge monitor pops and compares them against the DUT.
module tb_pipe_hazard_ctrl;

  typedef struct {
    logic [12:0] v;
    string       nm;
  } exp_t;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [4:0] id_rs_i, id_rt_i, ex_rs_i, ex_rt_i, ex_w_addr_i, mem_w_addr_i, wb_w_addr_i;
  logic       id_use_rs_i, id_use_rt_i, ex_reg_write_i, ex_dm_read_i;
  logic       mem_reg_write_i, wb_reg_write_i, branch_taken_i, dm_req_i, dm_ready_i;
  logic       pc_write_o, if_id_write_o, pipe_hold_o, id_ex_bubble_o;
  logic       if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_wb_bubble_o, err_o;
  logic [1:0] fwd_a_o, fwd_b_o;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_cnt_o, flush_cnt_o, memwait_cnt_o;
`endif

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk_i = ~clk_i;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(16), .RST_FLUSH_CYC(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
    .id_use_rs_i(id_use_rs_i), .id_use_rt_i(id_use_rt_i),
    .ex_rs_i(ex_rs_i), .ex_rt_i(ex_rt_i),
    .ex_reg_write_i(ex_reg_write_i), .ex_dm_read_i(ex_dm_read_i),
    .ex_w_addr_i(ex_w_addr_i),
    .mem_reg_write_i(mem_reg_write_i), .mem_w_addr_i(mem_w_addr_i),
    .wb_reg_write_i(wb_reg_write_i), .wb_w_addr_i(wb_w_addr_i),
    .branch_taken_i(branch_taken_i), .dm_req_i(dm_req_i), .dm_ready_i(dm_ready_i),
    .pc_write_o(pc_write_o), .if_id_write_o(if_id_write_o),
    .pipe_hold_o(pipe_hold_o), .id_ex_bubble_o(id_ex_bubble_o),
    .if_id_flush_o(if_id_flush_o), .id_ex_flush_o(id_ex_flush_o),
    .ex_mem_flush_o(ex_mem_flush_o), .mem_wb_bubble_o(mem_wb_bubble_o),
    .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o), .err_o(err_o)
`ifdef PIPE_HAZARD_PERF_EN
    , .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o), .memwait_cnt_o(memwait_cnt_o)
`endif
  );

  // Vector layout: pc, if_id_w, hold, id_ex_bubble, 3 flushes, mem_wb_bubble, fwd_a, fwd_b, err
  function automatic logic [12:0] mk(input logic pc, input logic ifw, input logic hold,
                                     input logic bub, input logic fl, input logic mwb,
                                     input logic [1:0] fa, input logic [1:0] fb,
                                     input logic er);
    return {pc, ifw, hold, bub, fl, fl, fl, mwb, fa, fb, er};
  endfunction

  logic [12:0] e_init, e_run, e_luse, e_br, e_stall, e_err;

  logic [12:0] act;
  assign act = {pc_write_o, if_id_write_o, pipe_hold_o, id_ex_bubble_o,
                if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_wb_bubble_o,
                fwd_a_o, fwd_b_o, err_o};

  always @(negedge clk_i) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (act !== e.v) begin
        errors++;
        $display("FAIL %s: got %b expected %b", e.nm, act, e.v);
      end
    end
  end

  task automatic cyc(input logic [12:0] v, input string nm);
    exp_t e;
    e.v  = v;
    e.nm = nm;
    sb.push_back(e);
    @(posedge clk_i);
    #1;
  endtask

  task automatic clr_in();
    id_rs_i = 0; id_rt_i = 0; id_use_rs_i = 0; id_use_rt_i = 0;
    ex_rs_i = 0; ex_rt_i = 0; ex_reg_write_i = 0; ex_dm_read_i = 0; ex_w_addr_i = 0;
    mem_reg_write_i = 0; mem_w_addr_i = 0; wb_reg_write_i = 0; wb_w_addr_i = 0;
    branch_taken_i = 0; dm_req_i = 0; dm_ready_i = 0;
  endtask

  initial begin
    e_init  = mk(0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0);
    e_run   = mk(1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    e_luse  = mk(0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0);
    e_br    = mk(1, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0);
    e_stall = mk(0, 0, 1, 0, 0, 1, 2'b00, 2'b00, 0);
    e_err   = mk(0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 1);

    rst_i = 1'b1;
    clr_in();
    @(posedge clk_i);
    #1;
    for (int i = 0; i < 3; i++) cyc(e_init, "in_reset");
    rst_i = 1'b0;
    cyc(e_init, "init_c0");
    cyc(e_init, "init_c1");
    cyc(e_run, "first_run");

    // load-use on rs, then the load has moved on
    ex_dm_read_i = 1; ex_reg_write_i = 1; ex_w_addr_i = 5'd2;
    id_rs_i = 5'd2; id_use_rs_i = 1;
    cyc(e_luse, "luse_rs");
    ex_dm_read_i = 0; ex_reg_write_i = 0;
    cyc(e_run, "luse_released");
    // $0 destination never stalls
    ex_dm_read_i = 1; ex_reg_write_i = 1; ex_w_addr_i = 5'd0; id_rs_i = 5'd0;
    cyc(e_run, "luse_r0");
    // rt match only counts when rt is actually read
    ex_w_addr_i = 5'd3; id_rs_i = 5'd7; id_rt_i = 5'd3; id_use_rt_i = 0;
    cyc(e_run, "luse_rt_unused");
    id_use_rt_i = 1;
    cyc(e_luse, "luse_rt");
    branch_taken_i = 1;
    cyc(e_br, "branch_over_luse");
    clr_in();
    cyc(e_run, "idle");

    // forwarding priority and $0 exclusion
    ex_rs_i = 5'd5; ex_rt_i = 5'd0;
    mem_reg_write_i = 1; mem_w_addr_i = 5'd5; wb_reg_write_i = 1; wb_w_addr_i = 5'd5;
    cyc(mk(1, 1, 0, 0, 0, 0, 2'b01, 2'b00, 0), "fwd_a_mem");
    mem_reg_write_i = 0;
    cyc(mk(1, 1, 0, 0, 0, 0, 2'b10, 2'b00, 0), "fwd_a_wb");
    mem_reg_write_i = 1; ex_rt_i = 5'd5; ex_rs_i = 5'd9;
    cyc(mk(1, 1, 0, 0, 0, 0, 2'b00, 2'b01, 0), "fwd_b_mem");
    mem_w_addr_i = 5'd0; wb_w_addr_i = 5'd0; ex_rs_i = 5'd0; ex_rt_i = 5'd0;
    cyc(e_run, "fwd_r0");
    clr_in();

    // DM wait: 5 low-ready cycles, branch ignored while waiting
    dm_req_i = 1;
    for (int i = 0; i < 5; i++) begin
      branch_taken_i = (i == 2);
      cyc(e_stall, "dm_wait");
    end
    branch_taken_i = 0; dm_ready_i = 1;
    cyc(e_run, "dm_ready_release");
    clr_in();
    cyc(e_run, "after_dm");

    // reset mid-wait, stale ready ignored during INIT
    dm_req_i = 1;
    cyc(e_stall, "midwait_enter");
    cyc(e_stall, "midwait_hold");
    rst_i = 1; dm_ready_i = 1;
    cyc(e_init, "midwait_reset");
    rst_i = 0;
    cyc(e_init, "stale_ready_c0");
    cyc(e_init, "stale_ready_c1");
    cyc(e_run, "run_req_ready");
    clr_in();

    // timeout: RUN entry + 16 MEM_WAIT cycles, then ERR
    dm_req_i = 1;
    for (int i = 0; i < 17; i++) cyc(e_stall, "timeout_wait");
    cyc(e_err, "timeout_err");
    dm_ready_i = 1;
    cyc(e_err, "err_sticky_ready");
    clr_in();
    cyc(e_err, "err_sticky_idle");
    rst_i = 1;
    cyc(e_init, "err_reset");
    rst_i = 0;
    cyc(e_init, "post_err_c0");
    cyc(e_init, "post_err_c1");
    cyc(e_run, "post_err_run");

    @(negedge clk_i);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
